// File: rtl/nes_dma_pkg.sv
`default_nettype none
// ============================================================================
// Package     : nes_dma_pkg
// Description : Shared types and constants for the $4014 OAM DMA engine.
//               dma_state_t - engine state encoding
//               OAMDMA_ADDR - CPU register address that starts a transfer
//               OAM_BYTES   - bytes copied per transfer
// Revision    : 1.0 - initial release
// ============================================================================
package nes_dma_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] OAMDMA_ADDR = 16'h4014;
  localparam int          OAM_BYTES   = 256;

endpackage : nes_dma_pkg
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_ctrl
// Description : 2A03-style OAM DMA engine. A CPU write to DMA_REG_ADDR halts
//               the CPU, takes over the mapper bus and copies XFER_LEN bytes
//               from page {data,00} into PPU sprite OAM, starting at the
//               current OAMADDR. One READ (get cycle) and one WRITE (put
//               cycle) per byte; an ALIGN cycle is inserted when the halt
//               cycle lands so that the first READ would be a put cycle.
//
// Ports       : clk            - system clock
//               reset          - asynchronous active-high reset
//               cpu_ce         - one-clk pulse per CPU cycle; state advances
//                                only when high
//               cpu_addr       - CPU address bus
//               cpu_data_out   - CPU write data
//               cpu_WE         - CPU write strobe
//               mem_data_in    - mapper read data for dma_addr
//               oam_addr_start - PPU OAMADDR, first OAM destination
//               cpu_halt       - CPU RDY low while high
//               oam_dma        - engine owns the mapper bus
//               dma_addr       - source address {page, idx}
//               dma_rd         - mapper read strobe (READ cycles)
//               oam_addr       - OAM write address
//               oam_data       - OAM write data
//               oam_WE         - OAM write strobe (one clk, WRITE cycles)
//
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_ctrl
  import nes_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = OAMDMA_ADDR,
  parameter int          XFER_LEN     = OAM_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_WE,
  input  logic [7:0]  mem_data_in,
  input  logic [7:0]  oam_addr_start,
  output logic        cpu_halt,
  output logic        oam_dma,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_WE
);

  // Count value held while the final byte of a transfer is being written.
  localparam logic [8:0] LAST_CNT = 9'(XFER_LEN - 1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  dma_state_t  state_q,   state_d;
  logic        cyc_odd_q, cyc_odd_d;   // CPU get(0)/put(1) parity
  logic [7:0]  page_q,    page_d;
  logic [7:0]  idx_q,     idx_d;
  logic [7:0]  dst_q,     dst_d;
  logic [7:0]  latch_q,   latch_d;
  logic [8:0]  cnt_q,     cnt_d;       // bytes already written this transfer

  // Registered outputs (oam_WE is qualified by cpu_ce below)
  logic        cpu_halt_q,  cpu_halt_d;
  logic        oam_dma_q,   oam_dma_d;
  logic [15:0] dma_addr_q,  dma_addr_d;
  logic        dma_rd_q,    dma_rd_d;
  logic [7:0]  oam_addr_q,  oam_addr_d;
  logic [7:0]  oam_data_q,  oam_data_d;
  logic        oam_wr_q,    oam_wr_d;

  logic        trigger;

  assign trigger = cpu_WE && (cpu_addr == DMA_REG_ADDR);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cyc_odd_d = cyc_odd_q;
    page_d    = page_q;
    idx_d     = idx_q;
    dst_d     = dst_q;
    latch_d   = latch_q;
    cnt_d     = cnt_q;

    if (cpu_ce) begin
      cyc_odd_d = ~cyc_odd_q;

      case (state_q)
        IDLE: begin
          if (trigger) begin
            page_d  = cpu_data_out;
            dst_d   = oam_addr_start;
            idx_d   = 8'h00;
            cnt_d   = 9'd0;
            state_d = HALT;
          end
        end

        // The cycle after HALT has the opposite parity of HALT itself, so a
        // HALT on a put cycle is followed directly by a get (READ) cycle.
        HALT: begin
          state_d = cyc_odd_q ? READ : ALIGN;
        end

        ALIGN: begin
          state_d = READ;
        end

        READ: begin
          latch_d = mem_data_in;
          state_d = WRITE;
        end

        WRITE: begin
          idx_d   = idx_q + 8'd1;
          dst_d   = dst_q + 8'd1;
          cnt_d   = cnt_q + 9'd1;
          state_d = (cnt_q == LAST_CNT) ? IDLE : READ;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so they line up with the
    // state register after the edge.
    cpu_halt_d = (state_d != IDLE);
    oam_dma_d  = (state_d == ALIGN) || (state_d == READ) || (state_d == WRITE);
    dma_addr_d = oam_dma_d ? {page_d, idx_d} : 16'h0000;
    dma_rd_d   = (state_d == READ);
    oam_wr_d   = (state_d == WRITE);
    oam_addr_d = oam_wr_d ? dst_d   : 8'h00;
    oam_data_d = oam_wr_d ? latch_d : 8'h00;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cyc_odd_q  <= 1'b0;
      page_q     <= 8'h00;
      idx_q      <= 8'h00;
      dst_q      <= 8'h00;
      latch_q    <= 8'h00;
      cnt_q      <= 9'd0;
      cpu_halt_q <= 1'b0;
      oam_dma_q  <= 1'b0;
      dma_addr_q <= 16'h0000;
      dma_rd_q   <= 1'b0;
      oam_addr_q <= 8'h00;
      oam_data_q <= 8'h00;
      oam_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_odd_q  <= cyc_odd_d;
      page_q     <= page_d;
      idx_q      <= idx_d;
      dst_q      <= dst_d;
      latch_q    <= latch_d;
      cnt_q      <= cnt_d;
      cpu_halt_q <= cpu_halt_d;
      oam_dma_q  <= oam_dma_d;
      dma_addr_q <= dma_addr_d;
      dma_rd_q   <= dma_rd_d;
      oam_addr_q <= oam_addr_d;
      oam_data_q <= oam_data_d;
      oam_wr_q   <= oam_wr_d;
    end
  end

  assign cpu_halt = cpu_halt_q;
  assign oam_dma  = oam_dma_q;
  assign dma_addr = dma_addr_q;
  assign dma_rd   = dma_rd_q;
  assign oam_addr = oam_addr_q;
  assign oam_data = oam_data_q;
  // Strobe is the single clk of cpu_ce that ends the WRITE cycle, so a
  // stalled cpu_ce never produces an extra OAM write.
  assign oam_WE   = oam_wr_q & cpu_ce;

endmodule : oam_dma_ctrl
`default_nettype wire

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- OAM DMA engine, $4014, directly upstream of the CPU memory mapper (WRAM).
- A CPU write to $4014 halts the CPU, takes over the mapper bus, and copies 256 bytes from CPU page XX00–XXFF into PPU sprite OAM.
- Asserts the mapper's oam_dma qualifier while it owns the bus.
- Cycle timing matches the 2A03: 513 or 514 halted CPU cycles.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer.
- XFER_LEN, 256, bytes copied per transfer.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_ce  in  1  CPU cycle enable; one-clk pulse per CPU cycle; all state advances only when high
- cpu_addr  in  16  CPU address bus
- cpu_data_out  in  8  CPU write data
- cpu_WE  in  1  CPU write strobe
- mem_data_in  in  8  read data returned by the mapper for dma_addr
- oam_addr_start  in  8  current PPU OAMADDR ($2003); first OAM destination
- cpu_halt  out  1  stalls the CPU (RDY low) while high
- oam_dma  out  1  high while the engine owns the mapper bus; mapper selects dma_addr over cpu_addr
- dma_addr  out  16  source address {page, idx}
- dma_rd  out  1  read strobe to the mapper, READ cycles only
- oam_addr  out  8  OAM write address
- oam_data  out  8  OAM write data
- oam_WE  out  1  OAM write strobe, WRITE cycles only

Behaviour:
- Reset (async, any state): state=IDLE; page=0; idx=0; cyc_odd=0; latch=0. All outputs 0.
- cyc_odd: toggles on every cpu_ce, in every state. It is the CPU get(0)/put(1) parity.
- Trigger, in IDLE: cpu_ce && cpu_WE && cpu_addr==DMA_REG_ADDR.
  - Latch page=cpu_data_out and dst=oam_addr_start.
  - Go to HALT.
  - The triggering CPU write completes normally.
- HALT: one CPU cycle. cpu_halt=1; oam_dma=0; no bus activity.
  - Exit to READ if the next cycle has cyc_odd==0, else to ALIGN.
- ALIGN: one CPU cycle. cpu_halt=1; oam_dma=1; no strobes. Then READ.
- READ (cyc_odd==0): dma_addr={page,idx}; dma_rd=1.
  - mem_data_in is captured into latch on the cpu_ce that ends the cycle.
  - Mapper read latency must fit within one CPU cycle.
  - Then WRITE.
- WRITE (cyc_odd==1): oam_addr=dst; oam_data=latch; oam_WE=cpu_ce (exactly one clk pulse).
  - On the ending cpu_ce: idx+=1 and dst+=1, both 8-bit wrap.
  - If the byte just written was number XFER_LEN, go to IDLE; else go to READ.
  - Byte counting uses a 9-bit counter or a done flag.
- Total halt: 1 + align(0/1) + 512 CPU cycles.
- cpu_halt=1 and oam_dma=1 in ALIGN/READ/WRITE. cpu_halt also =1 in HALT.
- cpu_halt falls on the clk after the last WRITE's cpu_ce.
- dst wraps: oam_addr_start=8'hF0 writes OAM F0..FF then 00..EF.
- Trigger while not IDLE is ignored. The CPU is halted, so this can only arise from a stray bus value.
- cpu_ce low: all state and outputs held; oam_WE=0.
- Reset mid-transfer: immediate IDLE, strobes drop asynchronously. No partial write is retried.
- Page 8'h40 etc. is passed through unchanged. Source decoding is the mapper's job.

Decomposition:
- Package nes_dma_pkg holds:
  - enum dma_state_t {IDLE, HALT, ALIGN, READ, WRITE}
  - OAMDMA_ADDR=16'h4014
  - OAM_BYTES=256
- Single module; no sub-module. The parity flop and counters are inline.

Test Plan:
- Trigger on a cpu_ce cycle with cyc_odd=0 (even), write 8'h02, oam_addr_start=0.
  - HALT, READ with dma_addr=16'h0200.
  - cpu_halt high exactly 513 CPU cycles.
  - OAM[0..255]==RAM[0x0200..0x02FF].
- Same test, triggered on an odd cycle.
  - One ALIGN cycle inserted; cpu_halt high 514 CPU cycles.
  - First dma_rd on an even cycle.
- oam_addr_start=8'hF0, page 8'h03 with RAM[0x0300+i]=i.
  - OAM[(0xF0+i)&0xFF]==i.
  - Last oam_addr=8'hEF.
- Assert reset after 100 bytes.
  - All outputs 0 the same clk; state IDLE.
  - A new $4014 write of 8'h05 starts a clean transfer from 16'h0500.
- Non-matching writes: 16'h4015 and 16'h2004 with cpu_WE=1, and a read of 16'h4014 with cpu_WE=0.
  - No transfer; cpu_halt stays 0.
- cpu_ce held low 10 clks mid-READ.
  - dma_addr stable, no extra oam_WE.
  - Transfer resumes and completes with correct byte count.
